// File: rtl/atm_pkg.sv
// Shared definitions for the ATM keypad front-end: key codes, entry modes,
// front-end state encoding, and the decimal accumulate step.
// Latency: n/a (constants and a pure function). Backpressure: n/a.
package atm_pkg;

   // Key codes above KEY_MAX_DIGIT that carry a meaning; 13-15 are dropped.
   localparam logic [3:0] KEY_MAX_DIGIT = 4'd9;
   localparam logic [3:0] KEY_ENTER     = 4'd10;
   localparam logic [3:0] KEY_CLEAR     = 4'd11;
   localparam logic [3:0] KEY_CANCEL    = 4'd12;

   // Entry mode as presented on the mode input.
   localparam logic MODE_PIN    = 1'b0;
   localparam logic MODE_AMOUNT = 1'b1;

   // Front-end state. HOLD parks the block after a completed or cancelled
   // entry until the session is dropped.
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_PIN    = 2'd1,
      ST_AMOUNT = 2'd2,
      ST_HOLD   = 2'd3
   } state_t;

   // acc*10 + d, built from two shifts so no multiplier is inferred.
   // Wraps modulo 2^32; the digit limit keeps real entries below that.
   function automatic logic [31:0] acc_mul10_add(input logic [31:0] acc,
                                                 input logic [3:0]  d);
      return (acc << 3) + (acc << 1) + {28'd0, d};
   endfunction

endpackage

// File: rtl/key_debouncer.sv
// Debounces a raw keypad level into one event per physical press.
// Latency: event registered on the DEBOUNCE_CYCLES-th stable press sample.
// Backpressure: none; the event is a one-cycle pulse that must be consumed.
//
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   key_pressed       raw key-down level (may bounce)
//   key_code          raw key identity, must be stable alongside the level
//   key_evt           one-cycle pulse per accepted press
//   key_evt_code      code of the accepted press, valid with key_evt
module key_debouncer #(
   parameter int DEBOUNCE_CYCLES = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_pressed,
   input  logic [3:0] key_code,
   output logic       key_evt,
   output logic [3:0] key_evt_code
);

   localparam int             CW       = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [CW-1:0]  CNT_ONE  = CW'(1);
   localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

   // held=0: waiting for a stable press; held=1: waiting for a stable release.
   logic          held;
   logic [CW-1:0] cnt;
   logic [3:0]    cand_code;

   always_ff @(posedge clk) begin
      if (rst) begin
         held         <= 1'b0;
         cnt          <= '0;
         cand_code    <= '0;
         key_evt      <= 1'b0;
         key_evt_code <= '0;
      end else begin
         key_evt <= 1'b0;
         if (!held) begin
            if (!key_pressed) begin
               cnt <= '0;
            end else if (cnt == '0 || key_code != cand_code) begin
               // First sample of a press, or the code moved under a held
               // key: this sample starts a fresh run for the new code.
               cnt       <= CNT_ONE;
               cand_code <= key_code;
            end else if (cnt == CNT_LAST) begin
               key_evt      <= 1'b1;
               key_evt_code <= cand_code;
               held         <= 1'b1;
               cnt          <= '0;
            end else begin
               cnt <= cnt + CNT_ONE;
            end
         end else begin
            // Any high sample during release restarts the release run.
            if (key_pressed) begin
               cnt <= '0;
            end else if (cnt == CNT_LAST) begin
               held <= 1'b0;
               cnt  <= '0;
            end else begin
               cnt <= cnt + CNT_ONE;
            end
         end
      end
   end

endmodule

// File: rtl/atm_keypad_frontend.sv
// Keypad front-end: debounced keys become PIN digit strobes or a binary amount.
// Latency: DEBOUNCE_CYCLES+1 edges from the first stable press sample to a strobe.
// Backpressure: none; all strobes are one-cycle pulses into the controller.
//
// Ports:
//   clk, rst                clock, synchronous active-high reset
//   key_pressed, key_code   raw keypad level and key identity
//   enable                  session active; low forces IDLE
//   mode                    0 = PIN entry, 1 = amount entry
//   digito_stb, digito      PIN digit strobe and held digit value
//   monto_stb, monto        amount strobe and held binary amount
//   cancel_stb              accepted CANCEL
//   entry_error             rejected key
//   digit_count             digits held in the current entry
module atm_keypad_frontend
   import atm_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES   = 4,
   parameter int PIN_DIGITS        = 4,
   parameter int MAX_AMOUNT_DIGITS = 9
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        key_pressed,
   input  logic [3:0]  key_code,
   input  logic        enable,
   input  logic        mode,
   output logic        digito_stb,
   output logic [3:0]  digito,
   output logic        monto_stb,
   output logic [31:0] monto,
   output logic        cancel_stb,
   output logic        entry_error,
   output logic [3:0]  digit_count
);

   localparam logic [3:0] PIN_LIM = 4'(PIN_DIGITS);
   localparam logic [3:0] AMT_LIM = 4'(MAX_AMOUNT_DIGITS);

   logic        key_evt;
   logic [3:0]  key_evt_code;
   state_t      state;
   logic [31:0] acc;

   logic        is_digit;
   logic        mode_changed;

   key_debouncer #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debouncer (
      .clk          (clk),
      .rst          (rst),
      .key_pressed  (key_pressed),
      .key_code     (key_code),
      .key_evt      (key_evt),
      .key_evt_code (key_evt_code)
   );

   assign is_digit     = (key_evt_code <= KEY_MAX_DIGIT);
   // Only meaningful in PIN/AMOUNT: the requested mode differs from the
   // entry state we are in.
   assign mode_changed = ((mode == MODE_AMOUNT) != (state == ST_AMOUNT));

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         acc         <= '0;
         digit_count <= '0;
         digito_stb  <= 1'b0;
         digito      <= '0;
         monto_stb   <= 1'b0;
         monto       <= '0;
         cancel_stb  <= 1'b0;
         entry_error <= 1'b0;
      end else begin
         digito_stb  <= 1'b0;
         monto_stb   <= 1'b0;
         cancel_stb  <= 1'b0;
         entry_error <= 1'b0;

         if (!enable) begin
            // Session drop wins over any key event this cycle.
            state       <= ST_IDLE;
            acc         <= '0;
            digit_count <= '0;
         end else begin
            case (state)
               ST_IDLE: begin
                  state       <= (mode == MODE_AMOUNT) ? ST_AMOUNT : ST_PIN;
                  acc         <= '0;
                  digit_count <= '0;
               end

               ST_HOLD: begin
                  acc         <= '0;
                  digit_count <= '0;
               end

               ST_PIN, ST_AMOUNT: begin
                  if (mode_changed) begin
                     // Switch entry type; a key landing in this cycle is lost.
                     state       <= (mode == MODE_AMOUNT) ? ST_AMOUNT : ST_PIN;
                     acc         <= '0;
                     digit_count <= '0;
                  end else if (key_evt) begin
                     if (key_evt_code == KEY_CANCEL) begin
                        cancel_stb  <= 1'b1;
                        acc         <= '0;
                        digit_count <= '0;
                        state       <= ST_HOLD;
                     end else if (state == ST_PIN) begin
                        if (is_digit) begin
                           if (digit_count < PIN_LIM) begin
                              digito_stb  <= 1'b1;
                              digito      <= key_evt_code;
                              digit_count <= digit_count + 4'd1;
                           end else begin
                              entry_error <= 1'b1;
                           end
                        end else if (key_evt_code == KEY_CLEAR) begin
                           digit_count <= '0;
                        end
                        // ENTER and codes 13-15 have no effect in PIN entry.
                     end else begin
                        if (is_digit) begin
                           if (acc == '0 && key_evt_code == 4'd0) begin
                              // Leading zero: not a significant digit.
                           end else if (digit_count >= AMT_LIM) begin
                              entry_error <= 1'b1;
                           end else begin
                              acc         <= acc_mul10_add(acc, key_evt_code);
                              digit_count <= digit_count + 4'd1;
                           end
                        end else if (key_evt_code == KEY_ENTER) begin
                           if (acc != '0) begin
                              monto       <= acc;
                              monto_stb   <= 1'b1;
                              acc         <= '0;
                              digit_count <= '0;
                              state       <= ST_HOLD;
                           end else begin
                              entry_error <= 1'b1;
                           end
                        end else if (key_evt_code == KEY_CLEAR) begin
                           acc         <= '0;
                           digit_count <= '0;
                        end
                        // Codes 13-15 are dropped.
                     end
                  end
               end

               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_atm_keypad_frontend.sv
// Directed bench for atm_keypad_frontend with DEBOUNCE_CYCLES=4.
module tb_atm_keypad_frontend;
   import atm_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic        key_pressed;
   logic [3:0]  key_code;
   logic        enable;
   logic        mode;
   logic        digito_stb;
   logic [3:0]  digito;
   logic        monto_stb;
   logic [31:0] monto;
   logic        cancel_stb;
   logic        entry_error;
   logic [3:0]  digit_count;

   int n_checks = 0;
   int n_errors = 0;

   // Pulse counters sampled on the falling edge, away from the active edge.
   int n_dig = 0, n_monto = 0, n_cancel = 0, n_err = 0, n_wide = 0;
   logic p_d = 1'b0, p_m = 1'b0, p_c = 1'b0, p_e = 1'b0;

   atm_keypad_frontend #(
      .DEBOUNCE_CYCLES   (4),
      .PIN_DIGITS        (4),
      .MAX_AMOUNT_DIGITS (9)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .key_pressed (key_pressed),
      .key_code    (key_code),
      .enable      (enable),
      .mode        (mode),
      .digito_stb  (digito_stb),
      .digito      (digito),
      .monto_stb   (monto_stb),
      .monto       (monto),
      .cancel_stb  (cancel_stb),
      .entry_error (entry_error),
      .digit_count (digit_count)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (digito_stb)  n_dig++;
      if (monto_stb)   n_monto++;
      if (cancel_stb)  n_cancel++;
      if (entry_error) n_err++;
      if ((digito_stb && p_d) || (monto_stb && p_m) ||
          (cancel_stb && p_c) || (entry_error && p_e)) n_wide++;
      p_d = digito_stb;
      p_m = monto_stb;
      p_c = cancel_stb;
      p_e = entry_error;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic press(input logic [3:0] code);
      key_code    = code;
      key_pressed = 1'b1;
      repeat (6) step();
      key_pressed = 1'b0;
      repeat (6) step();
   endtask

   task automatic cycle_enable();
      enable = 1'b0;
      step();
      enable = 1'b1;
      repeat (2) step();
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   initial begin
      rst = 1'b1; enable = 1'b0; mode = MODE_PIN; key_pressed = 1'b0; key_code = 4'd0;
      repeat (3) step();
      rst = 1'b0;
      step();
      check("rst_digito_stb", digito_stb, 0);
      check("rst_digito", digito, 0);
      check("rst_monto_stb", monto_stb, 0);
      check("rst_monto", monto, 0);
      check("rst_cancel", cancel_stb, 0);
      check("rst_error", entry_error, 0);
      check("rst_count", digit_count, 0);

      // PIN entry with exact latency on the first digit.
      enable = 1'b1;
      repeat (2) step();
      key_code = 4'd4; key_pressed = 1'b1;
      repeat (4) step();
      check("pin_lat_early", digito_stb, 0);
      step();
      check("pin_lat_stb", digito_stb, 1);
      check("pin_lat_digit", digito, 4);
      check("pin_cnt1", digit_count, 1);
      step();
      check("pin_stb_width", digito_stb, 0);
      key_pressed = 1'b0;
      repeat (6) step();
      press(4'd7);
      check("pin_digit2", digito, 7);
      press(4'd5);
      check("pin_digit3", digito, 5);
      press(4'd6);
      check("pin_strobes", n_dig, 4);
      check("pin_digit4", digito, 6);
      check("pin_cnt4", digit_count, 4);
      press(4'd1);
      check("pin_over_err", n_err, 1);
      check("pin_over_nostb", n_dig, 4);
      check("pin_over_digit", digito, 6);

      // Session drop mid-PIN restarts the count.
      enable = 1'b0;
      step();
      check("dis_cnt", digit_count, 0);
      enable = 1'b1;
      repeat (2) step();
      press(4'd9);
      check("reen_cnt", digit_count, 1);
      check("reen_digit", digito, 9);
      press(KEY_CLEAR);
      check("pin_clear", digit_count, 0);
      press(KEY_ENTER);
      press(4'd13);
      check("pin_ignored_err", n_err, 1);
      check("pin_ignored_stb", n_dig, 5);
      press(4'd2);
      check("pin_cnt_pre_mode", digit_count, 1);

      // Mode change clears, then amount entry 0,1,2,5,0,ENTER.
      mode = MODE_AMOUNT;
      step();
      check("mode_clr", digit_count, 0);
      step();
      press(4'd0);
      check("amt_lead_zero", digit_count, 0);
      press(4'd1); press(4'd2); press(4'd5); press(4'd0);
      check("amt_cnt4", digit_count, 4);
      press(KEY_ENTER);
      check("amt_stb", n_monto, 1);
      check("amt_1250", monto, 1250);
      check("amt_cnt_clr", digit_count, 0);

      // HOLD discards everything.
      press(4'd3); press(KEY_ENTER); press(KEY_CANCEL);
      check("hold_dig", n_dig, 6);
      check("hold_monto", n_monto, 1);
      check("hold_cancel", n_cancel, 0);
      check("hold_err", n_err, 1);
      check("hold_monto_val", monto, 1250);

      // Empty ENTER.
      cycle_enable();
      press(KEY_ENTER);
      check("empty_err", n_err, 2);
      check("empty_nostb", n_monto, 1);

      // Digits then CANCEL.
      press(4'd3); press(4'd0);
      check("cancel_pre_cnt", digit_count, 2);
      press(KEY_CANCEL);
      check("cancel_stb", n_cancel, 1);
      check("cancel_nomonto", n_monto, 1);
      check("cancel_cnt", digit_count, 0);

      // 8, CLEAR, 2, ENTER.
      cycle_enable();
      press(4'd8); press(KEY_CLEAR); press(4'd2); press(KEY_ENTER);
      check("clear_stb", n_monto, 2);
      check("clear_val", monto, 2);

      // Nine 9s, a rejected tenth, then ENTER.
      cycle_enable();
      for (int i = 0; i < 9; i++) press(4'd9);
      check("ovf_cnt9", digit_count, 9);
      press(4'd9);
      check("ovf_err", n_err, 3);
      check("ovf_cnt_hold", digit_count, 9);
      press(KEY_ENTER);
      check("ovf_stb", n_monto, 3);
      check("ovf_val", monto, 999999999);

      // Bounce: high 3, low 1, high 4, low 4 -> one event.
      cycle_enable();
      key_code = 4'd7;
      key_pressed = 1'b1; repeat (3) step();
      key_pressed = 1'b0; step();
      key_pressed = 1'b1; repeat (4) step();
      key_pressed = 1'b0; repeat (6) step();
      check("bounce_one", digit_count, 1);
      // Code change two samples into a hold restarts the count.
      key_code = 4'd3; key_pressed = 1'b1; repeat (2) step();
      key_code = 4'd8; repeat (3) step();
      check("restart_early", digit_count, 1);
      repeat (3) step();
      key_pressed = 1'b0; repeat (6) step();
      check("restart_evt", digit_count, 2);
      press(KEY_ENTER);
      check("restart_val", monto, 78);
      check("restart_stb", n_monto, 4);

      // Reset mid-amount with acc=56.
      cycle_enable();
      press(4'd5); press(4'd6);
      check("rstmid_cnt", digit_count, 2);
      rst = 1'b1;
      step();
      check("rstmid_monto", monto, 0);
      check("rstmid_count", digit_count, 0);
      check("rstmid_digito", digito, 0);
      check("rstmid_strobes", {28'd0, digito_stb, monto_stb, cancel_stb, entry_error}, 0);
      rst = 1'b0;
      repeat (2) step();
      press(KEY_ENTER);
      check("rstmid_acc_gone", n_err, 4);
      check("rstmid_nostb", n_monto, 4);
      check("strobe_width", n_wide, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/atm_keypad_frontend.md
# atm_keypad_frontend

Keypad front-end for the ATM datapath, on the input side of the ATM controller.
- Debounces raw key events from the keypad matrix.
- In PIN mode, forwards each digit as a one-cycle `digito_stb`/`digito` pair.
- In amount mode, accumulates decimal key presses into a 32-bit binary `monto` and issues `monto_stb` on ENTER.
- Its outputs drive the controller's `digito_stb`, `digito`, `monto_stb` and `monto` inputs directly.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable samples required to accept a press or a release (≥2).
- `PIN_DIGITS`, default 4: maximum digits forwarded per PIN entry.
- `MAX_AMOUNT_DIGITS`, default 9: maximum significant amount digits (999 999 999 < 2^32).
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `key_pressed` in 1: raw key-down level, may bounce.
- `key_code` in 4: key identity.
  - 0–9: digit.
  - 10: ENTER.
  - 11: CLEAR.
  - 12: CANCEL.
  - 13–15: ignored.
- `enable` in 1: session active (card accepted).
- `mode` in 1: entry mode, 0 = PIN, 1 = AMOUNT.
- `digito_stb` out 1: one-cycle PIN-digit strobe.
- `digito` out 4: PIN digit value; holds until the next `digito_stb`.
- `monto_stb` out 1: one-cycle amount-valid strobe.
- `monto` out 32: entered amount, binary; holds until the next `monto_stb`.
- `cancel_stb` out 1: one-cycle pulse on an accepted CANCEL.
- `entry_error` out 1: one-cycle pulse on a rejected key.
- `digit_count` out 4: digits held in the current entry.

## Operation
- **Debounce, press:** a press event is generated when `key_pressed`=1 with an unchanged `key_code` for `DEBOUNCE_CYCLES` consecutive samples. A code change while the key is held restarts the count.
- **Debounce, release:** after a press, no new event is accepted until `key_pressed`=0 for `DEBOUNCE_CYCLES` consecutive samples. One event per physical press.
- **States:**
  - IDLE: entered when `enable`=0.
  - PIN: entered when `enable`=1 and `mode`=0.
  - AMOUNT: entered when `enable`=1 and `mode`=1.
  - HOLD: entered after `monto_stb` or `cancel_stb`; left only through IDLE, i.e. when `enable` drops.
- **Mode change:** a change of `mode` while in PIN or AMOUNT clears the accumulator and `digit_count`, then enters the other entry state.
- **IDLE / HOLD:** all key events are discarded with no error pulse. The accumulator and `digit_count` are held at 0.
- **PIN state:**
  - Digit with `digit_count` < `PIN_DIGITS`: `digito_stb`=1, `digito`=code, `digit_count`+1.
  - Digit with `digit_count` = `PIN_DIGITS`: `entry_error`, nothing forwarded.
  - CLEAR: `digit_count`=0.
  - ENTER: ignored.
- **AMOUNT state:**
  - Digit: acc = acc·10 + d, computed as (acc<<3)+(acc<<1)+d in 32 bits.
  - A digit 0 while acc = 0 is a leading zero: acc unchanged, `digit_count` unchanged, no error.
  - Digit when `digit_count` = `MAX_AMOUNT_DIGITS`: `entry_error`, acc unchanged.
  - ENTER with acc ≠ 0: `monto`=acc, `monto_stb`=1, clear acc and `digit_count`, go to HOLD.
  - ENTER with acc = 0: `entry_error`, no strobe.
  - CLEAR: acc=0, `digit_count`=0.
- **CANCEL (PIN or AMOUNT):** `cancel_stb`=1, clear acc and `digit_count`, go to HOLD.
- **Codes 13–15:** dropped silently in every state.
- **At most one strobe per cycle**, since there is at most one key event per cycle.

## Timing
- **Reset values:** all outputs 0, including `digito`=0, `monto`=0 and `digit_count`=0. State IDLE; debouncer cleared and in released state.
- **`rst` mid-entry:** discards any partial entry; no strobe is emitted.
- **Latency:** key held stable from sampling edge 1. The debouncer registers the event on edge `DEBOUNCE_CYCLES`, and the FSM registers its outputs on the following edge. Total latency is `DEBOUNCE_CYCLES`+1 edges.
- **Strobe width:** every strobe and `entry_error` is exactly one cycle.
- **`enable` falling:** forces IDLE on the next edge and overrides a key event in the same cycle.
- **`mode` change:** takes effect on the next edge. A key event in that same cycle is discarded.

## Structure
- **Shared package `atm_pkg`:**
  - Key-code constants `KEY_ENTER`=10, `KEY_CLEAR`=11, `KEY_CANCEL`=12.
  - Mode constants `MODE_PIN`=0, `MODE_AMOUNT`=1.
  - The state encoding for IDLE/PIN/AMOUNT/HOLD.
- **Sub-module `key_debouncer`:**
  - Parameter `DEBOUNCE_CYCLES`.
  - Inputs `clk`, `rst`, `key_pressed`, `key_code`.
  - Outputs `key_evt` (one-cycle pulse) and `key_evt_code`.
  - Instantiated once.

## Test plan
- **PIN entry:** `DEBOUNCE_CYCLES`=4, `mode`=0, keys 4,7,5,6, each held 6 cycles with 6 released -> four `digito_stb` pulses, `digito`=4,7,5,6, each strobe 5 edges after its press starts. A 5th digit -> `entry_error`, no `digito_stb`.
- **Amount entry:** `mode`=1, keys 0,1,2,5,0,ENTER -> `monto_stb` with `monto`=1250; `digit_count` reaches 4; then HOLD ignores all keys until `enable`=0.
- **Bounce:** `key_pressed` high 3 cycles, low 1, high 4 with same code, then low 4 -> exactly one event. A code change at cycle 2 of the hold restarts the count.
- **Overflow limit:** 9 presses of 9 then ENTER -> `monto`=999999999. A 10th digit before ENTER -> `entry_error`, value unchanged.
- **Empty/cancel:** ENTER with acc=0 -> `entry_error` only. Digits 3,0 then CANCEL -> `cancel_stb`, no `monto_stb`. Digits 8,CLEAR,2,ENTER -> `monto`=2.
- **Reset/disable:** `rst` mid-amount (acc=56) -> all outputs 0 next edge, no strobe. `enable` dropped mid-PIN, then re-raised -> `digit_count` restarts at 0.
